// File: rtl/hc595_chain_arb.sv
// hc595_chain_arb: round-robin arbiter sharing one 74HC595 serial chain among several frame requesters
module hc595_chain_arb #(
  parameter int NUM_REQ = 4,
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 99
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*FRAME_W-1:0] frame_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [2:0]                 grant_id,
  output logic                       SH_CLK,
  output logic                       LD_CLK,
  output logic                       HC_DAT
);
  localparam int CW = CLK_DIV > 0 ? $clog2(CLK_DIV + 1) : 1;
  localparam int BW = $clog2(FRAME_W);
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_CLK, S_PRELD, S_LATCH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [FRAME_W-1:0] sr_q, sr_d, slice;
  logic [2:0] last_q, last_d, gid_q, gid_d, win;
  logic [NUM_REQ-1:0] ack_q, ack_d, done_q, done_d;
  logic busy_q, busy_d, sh_q, sh_d, ld_q, ld_d, dat_q, dat_d, tick, found;
  assign tick = cnt_q == CW'(CLK_DIV);
  assign slice = FRAME_W'(frame_data >> (int'(win) * FRAME_W));
  assign ack = ack_q;
  assign done = done_q;
  assign busy = busy_q;
  assign grant_id = gid_q;
  assign SH_CLK = sh_q;
  assign LD_CLK = ld_q;
  assign HC_DAT = dat_q;
  // winner is the first requesting index after the last grant, wrapping around
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && req[i] && i > int'(last_q)) begin
        win = 3'(i);
        found = 1'b1;
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && req[i] && i <= int'(last_q)) begin
        win = 3'(i);
        found = 1'b1;
      end
  end
  // tick-paced serialiser: DATA/CLK per bit, then PRELD/LATCH for the storage clock
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    sr_d = sr_q;
    last_d = last_q;
    gid_d = gid_q;
    ack_d = '0;
    done_d = '0;
    busy_d = busy_q;
    sh_d = sh_q;
    ld_d = ld_q;
    dat_d = dat_q;
    case (state_q)
      S_IDLE: if (|req) begin
        state_d = S_DATA;
        cnt_d = '0;
        sr_d = slice;
        bit_d = '0;
        last_d = win;
        gid_d = win;
        ack_d = NUM_REQ'(1) << win;
        busy_d = 1'b1;
        dat_d = slice[FRAME_W-1];
      end
      S_DATA: if (tick) begin
        sh_d = 1'b1;
        state_d = S_CLK;
      end
      S_CLK: if (tick) begin
        sh_d = 1'b0;
        if (bit_q == BW'(FRAME_W - 1)) begin
          dat_d = 1'b0;
          state_d = S_PRELD;
        end else begin
          sr_d = sr_q << 1;
          bit_d = bit_q + 1'b1;
          dat_d = sr_q[FRAME_W-2];
          state_d = S_DATA;
        end
      end
      S_PRELD: if (tick) begin
        ld_d = 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: if (tick) begin
        ld_d = 1'b0;
        done_d = NUM_REQ'(1) << gid_q;
        busy_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and registered outputs; reset discards any frame in flight
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sr_q <= '0;
      last_q <= 3'(NUM_REQ - 1);
      gid_q <= '0;
      ack_q <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
      sh_q <= 1'b0;
      ld_q <= 1'b0;
      dat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
      last_q <= last_d;
      gid_q <= gid_d;
      ack_q <= ack_d;
      done_q <= done_d;
      busy_q <= busy_d;
      sh_q <= sh_d;
      ld_q <= ld_d;
      dat_q <= dat_d;
    end
  end
endmodule
